sequential_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing a - b, one bit per clock, LSB first, using a registered borrow. It is the inverse-operation counterpart of the team's sequential_adder and uses the same start/done handshake, state/counter/borrow register structure and flag conventions, so the two can sit side by side in the datapath. Status outputs give unsigned borrow and two's-complement overflow.

---
 rtl/sub_pkg.sv | 7 +
 rtl/full_subtractor.sv | 11 +
 rtl/sequential_subtractor.sv | 95 +++++++++
 tb/tb_sequential_subtractor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared state encoding for the bit-serial subtractor, matching the sequential_adder
// encoding so both blocks decode state the same way.
package sub_pkg;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/sequential_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full_subtractor cell.
// Results and flags update only on the edge that enters DONE.
module sequential_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             a_msb;
  logic             b_msb;
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_nxt)
  );

  // The final bit enters from the MSB side, so res_nxt is the complete result on the last cycle.
  assign res_nxt = {d_bit, res[WIDTH-1:1]};

  assign busy = (state == S_CALC) || (state == S_DONE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      br       <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
            br    <= 1'b0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          res  <= res_nxt;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Counter parks at zero rather than stepping past WIDTH-1.
            cnt      <= '0;
            diff     <= res_nxt;
            borrow   <= br_nxt;
            overflow <= (a_msb != b_msb) && (d_bit != a_msb);
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_subtractor.sv
// Scoreboard bench for sequential_subtractor: expected results are queued when an
// operation is started and compared when done pulses.
module tb_sequential_subtractor;

  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bw;
    logic             ov;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             busy;
  logic             done;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sequential_subtractor #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_);
    exp_t e;
    logic [WIDTH:0] full;
    full = {1'b0, ta} - {1'b0, tb_};
    e.d  = full[WIDTH-1:0];
    e.bw = (ta < tb_);
    e.ov = (ta[WIDTH-1] != tb_[WIDTH-1]) && (e.d[WIDTH-1] != ta[WIDTH-1]);
    return e;
  endfunction

  // Drives one start pulse; returns 1 ns after the accept edge with operands scrambled.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input bit push);
    @(negedge clk);
    a = ta;
    b = tb_;
    start = 1'b1;
    if (push) sb.push_back(model(ta, tb_));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
  endtask

  // Counts edges from the accept edge (inclusive) until done, then scores the result.
  task automatic wait_done(input string tag, output int edges);
    exp_t e;
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!done) begin
      check_val({tag, "_timeout"}, 32'(done), 32'd1);
    end else if (sb.size() == 0) begin
      check_val({tag, "_unexpected_done"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check_val({tag, "_diff"}, 32'(diff), 32'(e.d));
      check_val({tag, "_borrow"}, 32'(borrow), 32'(e.bw));
      check_val({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
      check_val({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    check_val({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int edges;
    int dcount;

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    check_val("rst_diff", 32'(diff), 32'd0);
    check_val("rst_borrow", 32'(borrow), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    start_op(16'd300, 16'd100, 1'b1);
    wait_done("op300_100", edges);
    check_val("latency_edges", 32'(edges), 32'd17);

    // Held result must stay visible while the next operation is computing.
    start_op(16'd100, 16'd200, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_val("hold_mid_calc", 32'(diff), 32'd200);
    check_val("busy_mid_calc", 32'(busy), 32'd1);
    wait_done("op100_200", edges);

    start_op(16'd32767, 16'd65535, 1'b1);
    wait_done("op_max_minus1", edges);

    start_op(16'd32768, 16'd1, 1'b1);
    wait_done("op_min_1", edges);

    repeat (3) @(posedge clk);
    #1;
    check_val("hold_idle", 32'(diff), 32'd32767);

    // A second start during CALC must be ignored.
    start_op(16'd1234, 16'd1234, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 16'd5;
    b = 16'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("op_equal", edges);
    dcount = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check_val("ignored_start_no_extra_done", 32'(dcount), 32'd0);

    // Reset with counter at 7 discards the operation.
    start_op(16'd500, 16'd1, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_diff", 32'(diff), 32'd0);
    check_val("midrst_borrow", 32'(borrow), 32'd0);
    check_val("midrst_overflow", 32'(overflow), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check_val("midrst_no_done", 32'(dcount), 32'd0);
    check_val("midrst_diff_held", 32'(diff), 32'd0);

    start_op(16'd10, 16'd3, 1'b1);
    wait_done("op10_3", edges);

    for (int i = 0; i < 4; i++) begin
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
      wait_done("op_rand", edges);
    end

    check_val("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
